buffer_capture_ctrl: RTL and testbench

Sequences one-shot sample capture into a dual-port BRAM buffer: arm, wait for trigger, write cfg_length consecutive valid samples, then flag done for PS readout over the other BRAM port.
Sits between the ADC/acoustic sample stream (after the buffer register stage) and BRAM port A.
Owns all port-A write addressing and enables.

---
 rtl/buffer_capture_ctrl_pkg.sv | 16 +
 rtl/buffer_capture_ctrl_decim.sv | 31 +++
 rtl/buffer_capture_ctrl.sv | 121 ++++++++++++
 tb/tb_buffer_capture_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_capture_ctrl_pkg.sv
// buffer_ctrl_pkg: shared types and constants for the one-shot BRAM capture
// sequencer (buffer_capture_ctrl) and its optional decimator (buffer_decim).
//   cap_state_e : sequencer state, 2-bit encoding
//   DECIM_WIDTH : width of the decimation ratio field
package buffer_ctrl_pkg;

  localparam int DECIM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/buffer_capture_ctrl_decim.sv
// buffer_decim: valid-qualifying decimation counter. Passes the first valid
// after a restart, then every (cfg_decim+1)-th valid after that.
// Ports:
//   clk, aresetn : clock, synchronous active-low reset
//   restart      : clear the phase counter (issued on arm)
//   in_valid     : valid strobe already gated to the capture window
//   cfg_decim    : decimation ratio minus one (0 = keep every valid)
//   keep         : combinational, in_valid qualified by the decimator
module buffer_decim
  import buffer_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   restart,
  input  logic                   in_valid,
  input  logic [DECIM_WIDTH-1:0] cfg_decim,
  output logic                   keep
);

  logic [DECIM_WIDTH-1:0] cnt;

  // Phase 0 is the kept slot, so the first valid after restart is written.
  assign keep = in_valid && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!aresetn)       cnt <= '0;
    else if (restart)   cnt <= '0;
    else if (in_valid)  cnt <= (cnt == cfg_decim) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/buffer_capture_ctrl.sv
// buffer_capture_ctrl: one-shot capture sequencer driving BRAM port A.
// arm -> wait for trigger -> write cfg_length valid samples -> done.
// Optional macro BUFFER_CAPTURE_DECIM_EN adds cfg_decim and a decimator.
// Ports:
//   clk, aresetn           : clock, synchronous active-low reset
//   arm, abort, trigger    : control strobes (abort wins over arm)
//   cfg_length             : capture length, 0 = full depth, latched on arm
//   cfg_decim              : (macro only) decimation ratio minus one
//   in_data, in_valid      : sample stream, no backpressure
//   bram_addr/wrdata/we    : registered port-A write, one cycle after accept
//   busy, done             : ARMED|CAPTURE, DONE
//   sample_count           : words written in current/last capture
module buffer_capture_ctrl
  import buffer_ctrl_pkg::*;
#(
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       trigger,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_length,
`ifdef BUFFER_CAPTURE_DECIM_EN
  input  logic [DECIM_WIDTH-1:0]     cfg_decim,
`endif
  input  logic [BRAM_DATA_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram_wrdata,
  output logic                       bram_we,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH:0]   sample_count
);

  localparam int CW = BRAM_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_LEN = {1'b1, {BRAM_ADDR_WIDTH{1'b0}}};

  cap_state_e    state;
  logic [CW-1:0] len;
  logic [CW-1:0] cnt_nxt;
  logic          capt_win, arm_go, keep, acc, last;

  // Trigger cycle already counts as capture so a coincident valid is word 0.
  assign capt_win = (state == CAPTURE) || ((state == ARMED) && trigger);
  assign arm_go   = arm && !abort && ((state == IDLE) || (state == DONE));

`ifdef BUFFER_CAPTURE_DECIM_EN
  logic [DECIM_WIDTH-1:0] decim_q;

  always_ff @(posedge clk) begin
    if (!aresetn)    decim_q <= '0;
    else if (arm_go) decim_q <= cfg_decim;
  end

  // Only valids inside the capture window advance the decimation phase.
  buffer_decim u_decim (
    .clk      (clk),
    .aresetn  (aresetn),
    .restart  (arm_go),
    .in_valid (in_valid && capt_win && !abort),
    .cfg_decim(decim_q),
    .keep     (keep)
  );
`else
  assign keep = in_valid;
`endif

  assign acc     = keep && capt_win && !abort;
  assign cnt_nxt = sample_count + 1'b1;
  assign last    = acc && (cnt_nxt == len);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state        <= IDLE;
      len          <= '0;
      sample_count <= '0;
      bram_addr    <= '0;
      bram_wrdata  <= '0;
      bram_we      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      bram_we <= acc;
      if (acc) begin
        bram_addr    <= sample_count[BRAM_ADDR_WIDTH-1:0];
        bram_wrdata  <= in_data;
        sample_count <= cnt_nxt;
      end

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (arm) begin
            state        <= ARMED;
            busy         <= 1'b1;
            done         <= 1'b0;
            len          <= (cfg_length == '0) ? FULL_LEN : {1'b0, cfg_length};
            sample_count <= '0;
          end
          ARMED, CAPTURE: begin
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (capt_win) begin
              state <= CAPTURE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buffer_capture_ctrl.sv
module tb_buffer_capture_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  localparam int GUARD = 20000;

  logic          clk = 1'b0;
  logic          aresetn, arm, abort, trigger, in_valid;
  logic [AW-1:0] cfg_length;
  logic [15:0]   cfg_decim;
  logic [DW-1:0] in_data;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wrdata;
  logic          bram_we, busy, done;
  logic [AW:0]   sample_count;

  always #5 clk = ~clk;

  buffer_capture_ctrl #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .aresetn(aresetn), .arm(arm), .abort(abort), .trigger(trigger),
    .cfg_length(cfg_length),
`ifdef BUFFER_CAPTURE_DECIM_EN
    .cfg_decim(cfg_decim),
`endif
    .in_data(in_data), .in_valid(in_valid),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_we(bram_we),
    .busy(busy), .done(done), .sample_count(sample_count)
  );

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    bit            last;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the next expected write.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                 bram_addr, bram_wrdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bram_addr), 64'(e.addr));
        chk("wr_data", 64'(bram_wrdata), 64'(e.data));
        chk("wr_done", 64'(done), 64'(e.last));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int len_cfg, input int decim);
    arm        = 1'b1;
    cfg_length = AW'(len_cfg);
    cfg_decim  = 16'(decim);
    cyc();
    arm = 1'b0;
  endtask

  // Reference: from the trigger cycle on, valid samples are numbered k=0,1,..;
  // those with k % (decim+1) == 0 become words 0..L-1 in order.
  task automatic run_capture(input int len_cfg, input int pv, input int pre, input int decim);
    int L, n, k, guard;
    bit first;
    L = (len_cfg == 0) ? DEPTH : len_cfg;
    do_arm(len_cfg, decim);
    chk("arm_busy", 64'(busy), 64'd1);
    chk("arm_done", 64'(done), 64'd0);
    chk("arm_count", 64'(sample_count), 64'd0);
    repeat (pre) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      cyc();
    end
    n = 0; k = 0; guard = 0; first = 1'b1;
    while (n < L && guard < GUARD) begin
      trigger  = first;
      arm      = !first && ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 99) < pv);
      in_data  = $urandom;
      if (in_valid) begin
        if (k % (decim + 1) == 0) begin
          exp_q.push_back('{n, in_data, (n + 1 == L)});
          n++;
        end
        k++;
      end
      cyc();
      first = 1'b0;
      guard++;
    end
    trigger = 1'b0; arm = 1'b0; in_valid = 1'b0;
    if (guard >= GUARD) chk("capture_timeout", 64'(guard), 64'd0);
    chk("end_done", 64'(done), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_count", 64'(sample_count), 64'(L));
    repeat (3) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      trigger  = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b0; trigger = 1'b0;
    chk("hold_done", 64'(done), 64'd1);
    chk("hold_count", 64'(sample_count), 64'(L));
  endtask

  initial begin
    int dmax;
`ifdef BUFFER_CAPTURE_DECIM_EN
    dmax = 3;
`else
    dmax = 0;
`endif
    aresetn = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0; in_valid = 1'b0;
    cfg_length = '0; cfg_decim = '0; in_data = '0;
    cyc(); cyc();
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_data", 64'(bram_wrdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(sample_count), 64'd0);
    aresetn = 1'b1;

    // Trigger and valids in IDLE are ignored.
    trigger = 1'b1; in_valid = 1'b1;
    repeat (3) begin in_data = $urandom; cyc(); end
    trigger = 1'b0; in_valid = 1'b0;
    chk("idle_trig_busy", 64'(busy), 64'd0);
    chk("idle_trig_count", 64'(sample_count), 64'd0);

    run_capture(4, 100, 0, 0);   // basic
    run_capture(3, 33, 2, 0);    // sparse valids, pre-trigger noise
    run_capture(2, 70, 1, 0);    // re-arm from DONE
    run_capture(0, 100, 0, 0);   // full depth
    repeat (6) run_capture($urandom_range(1, 20), $urandom_range(20, 100),
                           $urandom_range(0, 3), $urandom_range(0, dmax));

    // Abort after 5 of 8 writes.
    do_arm(8, 0);
    trigger = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      exp_q.push_back('{i, in_data, 1'b0});
      cyc();
      trigger = 1'b0;
    end
    in_valid = 1'b0; abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_count", 64'(sample_count), 64'd5);
    in_valid = 1'b1; trigger = 1'b1;
    repeat (3) begin in_data = $urandom; cyc(); end
    in_valid = 1'b0; trigger = 1'b0;
    chk("abort_hold_count", 64'(sample_count), 64'd5);

    // Arm and abort together: abort wins.
    arm = 1'b1; abort = 1'b1; cfg_length = AW'(4);
    cyc();
    arm = 1'b0; abort = 1'b0;
    chk("armabort_busy", 64'(busy), 64'd0);
    in_valid = 1'b1; trigger = 1'b1;
    repeat (3) begin in_data = $urandom; cyc(); end
    in_valid = 1'b0; trigger = 1'b0;
    chk("armabort_count", 64'(sample_count), 64'd5);

    // Reset mid-capture.
    do_arm(8, 0);
    trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      exp_q.push_back('{i, in_data, 1'b0});
      cyc();
      trigger = 1'b0;
    end
    aresetn = 1'b0; in_data = $urandom;
    cyc();
    in_valid = 1'b0;
    chk("mrst_we", 64'(bram_we), 64'd0);
    chk("mrst_addr", 64'(bram_addr), 64'd0);
    chk("mrst_data", 64'(bram_wrdata), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_count", 64'(sample_count), 64'd0);
    aresetn = 1'b1;
    cyc();

    run_capture(5, 60, 1, 0);
`ifdef BUFFER_CAPTURE_DECIM_EN
    run_capture(3, 100, 0, 2);
`endif

    cyc(); cyc();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
